// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared note/song widths, rest code and sequencer states
package music_pkg;

  localparam int NOTE_W = 5;
  localparam int SONG_W = 2;
  localparam logic [NOTE_W-1:0] NOTE_REST = 5'd25;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    SFX
  } state_t;

endpackage

// File: rtl/tempo_ticker.sv
// rtl/tempo_ticker.sv - free-running step divider, tick on the last count
module tempo_ticker #(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - song stepper with one-shot SFX pre-emption and resume
module song_sequencer
  import music_pkg::*;
#(
  parameter int TICK_DIV = 10_000_000,
  parameter int SONG_LEN = 112,
  parameter int ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              play,
  input  logic              stop,
  input  logic [SONG_W-1:0] song_sel,
  input  logic              loop,
  input  logic              sfx_req,
  input  logic [NOTE_W-1:0] sfx_note,
  input  logic [7:0]        sfx_len,
  output logic [SONG_W-1:0] rom_song,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W-1:0] rom_data,
  output logic [NOTE_W-1:0] note_out,
  output logic              playing,
  output logic              sfx_busy,
  output logic              song_done
);

  localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(SONG_LEN - 1);

  state_t              state, state_nx;
  state_t              resume, resume_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic [SONG_W-1:0]   song_nx;
  logic                loop_q, loop_nx;
  logic [NOTE_W-1:0]   sfx_note_q, sfx_note_nx;
  logic [7:0]          remaining, remaining_nx;
  logic [NOTE_W-1:0]   note_nx;
  logic                done_nx;
  logic                restart;
  logic                tick;
  logic                clr;

  // Any state change, and a play restart inside PLAY, starts a fresh step.
  assign clr = (state_nx != state) || restart;

  tempo_ticker #(.TICK_DIV(TICK_DIV)) u_ticker (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .tick (tick)
  );

  assign playing  = (state == PLAY) || ((state == SFX) && (resume == PLAY));
  assign sfx_busy = (state == SFX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      resume     <= IDLE;
      rom_addr   <= '0;
      rom_song   <= '0;
      loop_q     <= 1'b0;
      sfx_note_q <= '0;
      remaining  <= '0;
      note_out   <= NOTE_REST;
      song_done  <= 1'b0;
    end else begin
      state      <= state_nx;
      resume     <= resume_nx;
      rom_addr   <= addr_nx;
      rom_song   <= song_nx;
      loop_q     <= loop_nx;
      sfx_note_q <= sfx_note_nx;
      remaining  <= remaining_nx;
      note_out   <= note_nx;
      song_done  <= done_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    resume_nx    = resume;
    addr_nx      = rom_addr;
    song_nx      = rom_song;
    loop_nx      = loop_q;
    sfx_note_nx  = sfx_note_q;
    remaining_nx = remaining;
    done_nx      = 1'b0;
    restart      = 1'b0;

    case (state)
      PLAY:    note_nx = rom_data;
      SFX:     note_nx = sfx_note_q;
      default: note_nx = NOTE_REST;
    endcase

    if (stop) begin
      state_nx = IDLE;
      addr_nx  = '0;
      note_nx  = NOTE_REST;
    end else if (state == SFX) begin
      if (play) begin
        song_nx   = song_sel;
        loop_nx   = loop;
        addr_nx   = '0;
        resume_nx = PLAY;
      end
      if (tick) begin
        remaining_nx = remaining - 8'd1;
        if (remaining == 8'd1) state_nx = resume_nx;
      end
    end else begin
      if (play) begin
        song_nx = song_sel;
        loop_nx = loop;
        addr_nx = '0;
      end
      // SFX wins over play; a simultaneous play only sets up the resume target.
      if (sfx_req) begin
        state_nx     = SFX;
        resume_nx    = (play || state == PLAY) ? PLAY : IDLE;
        sfx_note_nx  = sfx_note;
        remaining_nx = (sfx_len == 8'd0) ? 8'd1 : sfx_len;
      end else if (play) begin
        state_nx = PLAY;
        restart  = 1'b1;
      end else if (state == PLAY && tick) begin
        if (rom_addr != LAST_STEP) begin
          addr_nx = rom_addr + 1'b1;
        end else begin
          addr_nx = '0;
          if (!loop_q) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - scoreboard bench for song_sequencer
module tb_song_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       play = 1'b0, stop = 1'b0, loop = 1'b0, sfx_req = 1'b0;
  logic [1:0] song_sel = '0;
  logic [4:0] sfx_note = '0;
  logic [7:0] sfx_len = '0;
  logic [1:0] rom_song;
  logic [2:0] rom_addr;
  logic [4:0] rom_data;
  logic [4:0] note_out;
  logic       playing, sfx_busy, song_done;

  typedef struct packed {
    logic [4:0] note;
    logic       playing;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  assign rom_data = 5'(rom_addr) + 5'(rom_song) * 5'd8;

  song_sequencer #(.TICK_DIV(4), .SONG_LEN(8), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .play(play), .stop(stop), .song_sel(song_sel),
    .loop(loop), .sfx_req(sfx_req), .sfx_note(sfx_note), .sfx_len(sfx_len),
    .rom_song(rom_song), .rom_addr(rom_addr), .rom_data(rom_data),
    .note_out(note_out), .playing(playing), .sfx_busy(sfx_busy), .song_done(song_done)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sb.push_back('{5'd25, 1'b0, 1'b0, 1'b0});
      cyc();
      e = sb.pop_front();
      n_cmp++;
      if ({note_out, playing, sfx_busy, song_done} !== e || rom_addr !== 3'd0 || rom_song !== 2'd0) begin
        n_err++;
        $display("FAIL reset[%0d] got note=%0d pl=%b busy=%b done=%b addr=%0d want %0d %b %b %b addr=0",
                 i, note_out, playing, sfx_busy, song_done, rom_addr, e.note, e.playing, e.busy, e.done);
      end
    end
  endtask

  task automatic test_play_once();
    play = 1'b1; song_sel = 2'd1; loop = 1'b0;
    cyc();
    play = 1'b0;
    for (int i = 0; i < 33; i++)
      sb.push_back('{(i < 32) ? 5'(8 + i / 4) : 5'd25, (i < 31), 1'b0, (i == 31)});
    for (int i = 0; i < 33; i++) begin
      cyc();
      e = sb.pop_front();
      n_cmp++;
      if ({note_out, playing, sfx_busy, song_done} !== e) begin
        n_err++;
        $display("FAIL play_once[%0d] got note=%0d pl=%b busy=%b done=%b want %0d %b %b %b",
                 i, note_out, playing, sfx_busy, song_done, e.note, e.playing, e.busy, e.done);
      end
    end
    n_cmp++;
    if (rom_addr !== 3'd0 || rom_song !== 2'd1) begin
      n_err++;
      $display("FAIL play_once_rom got addr=%0d song=%0d want 0 1", rom_addr, rom_song);
    end
  endtask

  task automatic test_loop_stop();
    play = 1'b1; song_sel = 2'd1; loop = 1'b1;
    cyc();
    play = 1'b0;
    for (int i = 0; i < 40; i++)
      sb.push_back('{5'(8 + (i / 4) % 8), 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 40; i++) begin
      cyc();
      e = sb.pop_front();
      n_cmp++;
      if ({note_out, playing, sfx_busy, song_done} !== e) begin
        n_err++;
        $display("FAIL loop[%0d] got note=%0d pl=%b busy=%b done=%b want %0d %b %b %b",
                 i, note_out, playing, sfx_busy, song_done, e.note, e.playing, e.busy, e.done);
      end
    end
    stop = 1'b1;
    sb.push_back('{5'd25, 1'b0, 1'b0, 1'b0});
    cyc();
    stop = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if ({note_out, playing, sfx_busy, song_done} !== e || rom_addr !== 3'd0) begin
      n_err++;
      $display("FAIL loop_stop got note=%0d pl=%b addr=%0d want %0d %b addr=0",
               note_out, playing, rom_addr, e.note, e.playing);
    end
  endtask

  task automatic test_sfx_resume();
    play = 1'b1; song_sel = 2'd1; loop = 1'b0;
    cyc();
    play = 1'b0;
    for (int i = 0; i < 13; i++) sb.push_back('{5'(8 + i / 4), 1'b1, 1'b0, 1'b0});
    sb.push_back('{5'd11, 1'b1, 1'b1, 1'b0});
    for (int i = 0; i < 8; i++) sb.push_back('{5'd2, 1'b1, (i < 7), 1'b0});
    for (int i = 0; i < 8; i++) sb.push_back('{(i < 4) ? 5'd11 : 5'd12, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 30; i++) begin
      sfx_req = (i == 13); sfx_note = 5'd2; sfx_len = 8'd2;
      cyc();
      sfx_req = 1'b0;
      e = sb.pop_front();
      n_cmp++;
      if ({note_out, playing, sfx_busy, song_done} !== e) begin
        n_err++;
        $display("FAIL sfx_resume[%0d] got note=%0d pl=%b busy=%b done=%b want %0d %b %b %b",
                 i, note_out, playing, sfx_busy, song_done, e.note, e.playing, e.busy, e.done);
      end
    end
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic test_sfx_len0();
    sfx_req = 1'b1; sfx_note = 5'd5; sfx_len = 8'd0;
    sb.push_back('{5'd25, 1'b0, 1'b1, 1'b0});
    cyc();
    sfx_req = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if ({note_out, playing, sfx_busy, song_done} !== e) begin
      n_err++;
      $display("FAIL sfx_len0_entry got note=%0d pl=%b busy=%b want %0d %b %b",
               note_out, playing, sfx_busy, e.note, e.playing, e.busy);
    end
    for (int i = 0; i < 8; i++) sb.push_back('{(i < 4) ? 5'd5 : 5'd25, 1'b0, (i < 3), 1'b0});
    for (int i = 0; i < 8; i++) begin
      sfx_req = (i == 1); sfx_note = 5'd7; sfx_len = 8'd9;
      cyc();
      sfx_req = 1'b0;
      e = sb.pop_front();
      n_cmp++;
      if ({note_out, playing, sfx_busy, song_done} !== e) begin
        n_err++;
        $display("FAIL sfx_len0[%0d] got note=%0d pl=%b busy=%b done=%b want %0d %b %b %b",
                 i, note_out, playing, sfx_busy, song_done, e.note, e.playing, e.busy, e.done);
      end
    end
  endtask

  task automatic test_priority_and_play_in_sfx();
    stop = 1'b1; play = 1'b1; sfx_req = 1'b1; song_sel = 2'd3; sfx_note = 5'd1; sfx_len = 8'd3;
    for (int i = 0; i < 3; i++) sb.push_back('{5'd25, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++) begin
      cyc();
      stop = 1'b0; play = 1'b0; sfx_req = 1'b0;
      e = sb.pop_front();
      n_cmp++;
      if ({note_out, playing, sfx_busy, song_done} !== e || rom_addr !== 3'd0) begin
        n_err++;
        $display("FAIL all_cmds[%0d] got note=%0d pl=%b busy=%b addr=%0d want %0d %b %b addr=0",
                 i, note_out, playing, sfx_busy, rom_addr, e.note, e.playing, e.busy);
      end
    end
    sfx_req = 1'b1; sfx_note = 5'd3; sfx_len = 8'd1;
    cyc();
    sfx_req = 1'b0;
    for (int i = 0; i < 12; i++)
      sb.push_back('{(i < 4) ? 5'd3 : (i < 8) ? 5'd16 : 5'd17, 1'b1, (i < 3), 1'b0});
    for (int i = 0; i < 12; i++) begin
      play = (i == 0); song_sel = 2'd2; loop = 1'b0;
      cyc();
      play = 1'b0;
      e = sb.pop_front();
      n_cmp++;
      if ({note_out, playing, sfx_busy, song_done} !== e) begin
        n_err++;
        $display("FAIL play_in_sfx[%0d] got note=%0d pl=%b busy=%b done=%b want %0d %b %b %b",
                 i, note_out, playing, sfx_busy, song_done, e.note, e.playing, e.busy, e.done);
      end
    end
    n_cmp++;
    if (rom_song !== 2'd2) begin
      n_err++;
      $display("FAIL play_in_sfx_song got %0d want 2", rom_song);
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0; play = 1'b1; sfx_req = 1'b1; song_sel = 2'd1;
    cyc();
    rst_n = 1'b1; play = 1'b0; sfx_req = 1'b0;
    sb.push_back('{5'd25, 1'b0, 1'b0, 1'b0});
    e = sb.pop_front();
    n_cmp++;
    if ({note_out, playing, sfx_busy, song_done} !== e || rom_addr !== 3'd0 || rom_song !== 2'd0) begin
      n_err++;
      $display("FAIL reset_mid got note=%0d pl=%b busy=%b addr=%0d song=%0d want 25 0 0 addr=0 song=0",
               note_out, playing, sfx_busy, rom_addr, rom_song);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_play_once();
    test_loop_stop();
    test_sfx_resume();
    test_sfx_len0();
    test_priority_and_play_in_sfx();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_left got %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
